// File: rtl/divisor_arbitro_if.sv
// Purpose: groups every non-clock signal of the divider arbiter into one bundle.
//   It covers the two requester channels and the link to the shared divider.
//   master: the arbiter side (divisor_arbitro).
//   slave : the environment side, meaning the requesters and the divider.
// Signals:
//   sol_0/sol_1, dd_0/dd_1, dv_0/dv_1 : request, dividend and divisor per channel
//   ack_0/ack_1, resultado, error     : per-channel completion pulse, quotient and error flag
//   ocupado                           : arbiter busy
//   dividendo, divisor, inicie        : operands and go to the divider
//   termino, cociente                 : divider done/ready and quotient
interface divisor_arbitro_if #(
  parameter int DD_W = 32,
  parameter int DV_W = 16,
  parameter int Q_W  = 32
);
  logic            sol_0;
  logic            sol_1;
  logic [DD_W-1:0] dd_0;
  logic [DD_W-1:0] dd_1;
  logic [DV_W-1:0] dv_0;
  logic [DV_W-1:0] dv_1;
  logic            ack_0;
  logic            ack_1;
  logic [Q_W-1:0]  resultado;
  logic            error;
  logic            ocupado;
  logic [DD_W-1:0] dividendo;
  logic [DV_W-1:0] divisor;
  logic            inicie;
  logic            termino;
  logic [Q_W-1:0]  cociente;

  modport master (
    input  sol_0, sol_1, dd_0, dd_1, dv_0, dv_1, termino, cociente,
    output ack_0, ack_1, resultado, error, ocupado, dividendo, divisor, inicie
  );

  modport slave (
    output sol_0, sol_1, dd_0, dd_1, dv_0, dv_1, termino, cociente,
    input  ack_0, ack_1, resultado, error, ocupado, dividendo, divisor, inicie
  );
endinterface

// File: rtl/divisor_arbitro.sv
// Purpose: shares one multicycle divider between two requesters.
//   Arbitration between the two channels is round-robin.
//   The operands of the granted channel are captured in registers.
//   The arbiter runs the inicie/termino handshake with the divider.
//   The quotient is returned with a one-cycle ack on the granted channel.
//   A zero divisor is answered at once with all-ones and error, and the divider is not started.
//   A watchdog bounds each wait on the divider to T_MAX cycles.
//   When the watchdog expires, the request is answered with zero and error.
// Ports:
//   reloj : clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : divisor_arbitro_if.master, carrying the requester channels and the divider link
module divisor_arbitro #(
  parameter int DD_W  = 32,
  parameter int DV_W  = 16,
  parameter int Q_W   = 32,
  parameter int T_MAX = 1024
) (
  input  logic             reloj,
  input  logic             reset,
  divisor_arbitro_if.master bus
);

  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA_LISTO,
    LANZA,
    ESPERA_BAJA,
    ESPERA_ALTA,
    ENTREGA
  } estado_t;

  // The watchdog fires after T_MAX cycles spent in one waiting state.
  localparam logic [15:0] WD_LIM = 16'(T_MAX - 1);

  estado_t         estado_q, estado_d;
  logic            canal_q, canal_d;
  logic            prioridad_q, prioridad_d;
  logic [DD_W-1:0] dividendo_q, dividendo_d;
  logic [DV_W-1:0] divisor_q, divisor_d;
  logic [Q_W-1:0]  resultado_q, resultado_d;
  logic            error_q, error_d;
  logic            ack_0_q, ack_0_d;
  logic            ack_1_q, ack_1_d;
  logic            inicie_q, inicie_d;
  logic            ocupado_q, ocupado_d;
  logic [15:0]     wd_q, wd_d;
  logic            grant;
  logic            wd_fin;
  logic            espera;

  // State register and all registered outputs.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      canal_q     <= 1'b0;
      prioridad_q <= 1'b0;
      dividendo_q <= '0;
      divisor_q   <= '0;
      resultado_q <= '0;
      error_q     <= 1'b0;
      ack_0_q     <= 1'b0;
      ack_1_q     <= 1'b0;
      inicie_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      estado_q    <= estado_d;
      canal_q     <= canal_d;
      prioridad_q <= prioridad_d;
      dividendo_q <= dividendo_d;
      divisor_q   <= divisor_d;
      resultado_q <= resultado_d;
      error_q     <= error_d;
      ack_0_q     <= ack_0_d;
      ack_1_q     <= ack_1_d;
      inicie_q    <= inicie_d;
      ocupado_q   <= ocupado_d;
      wd_q        <= wd_d;
    end
  end

  // Next-state logic.
  // Requests are looked at only in OCIOSO, so a channel that drops sol early
  // still has its operation completed.
  // Once ENTREGA has been visited, the same channel can be granted again no
  // earlier than the cycle after its ack.
  // The outputs are decoded from the next state, so that each one changes
  // on the same edge as the state it belongs to.
  always_comb begin
    estado_d    = estado_q;
    canal_d     = canal_q;
    prioridad_d = prioridad_q;
    dividendo_d = dividendo_q;
    divisor_d   = divisor_q;
    resultado_d = resultado_q;
    error_d     = error_q;
    grant       = 1'b0;
    wd_fin      = (wd_q == WD_LIM);

    case (estado_q)
      OCIOSO: begin
        if (bus.sol_0 || bus.sol_1) begin
          grant       = (bus.sol_0 && bus.sol_1) ? prioridad_q : bus.sol_1;
          canal_d     = grant;
          dividendo_d = grant ? bus.dd_1 : bus.dd_0;
          divisor_d   = grant ? bus.dv_1 : bus.dv_0;
          if (divisor_d == '0) begin
            estado_d    = ENTREGA;
            resultado_d = '1;
            error_d     = 1'b1;
          end else begin
            estado_d = ESPERA_LISTO;
          end
        end
      end
      ESPERA_LISTO: begin
        if (bus.termino) begin
          estado_d = LANZA;
        end else if (wd_fin) begin
          estado_d    = ENTREGA;
          resultado_d = '0;
          error_d     = 1'b1;
        end
      end
      LANZA: begin
        estado_d = ESPERA_BAJA;
      end
      ESPERA_BAJA: begin
        // A low termino while inicie is high means the divider took the operands.
        if (!bus.termino) begin
          estado_d = ESPERA_ALTA;
        end else if (wd_fin) begin
          estado_d    = ENTREGA;
          resultado_d = '0;
          error_d     = 1'b1;
        end
      end
      ESPERA_ALTA: begin
        if (bus.termino) begin
          estado_d    = ENTREGA;
          resultado_d = bus.cociente;
          error_d     = 1'b0;
        end else if (wd_fin) begin
          estado_d    = ENTREGA;
          resultado_d = '0;
          error_d     = 1'b1;
        end
      end
      ENTREGA: begin
        prioridad_d = ~canal_q;
        estado_d    = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // The watchdog restarts on every state change.
    // It only runs while waiting on the divider.
    espera = (estado_q == ESPERA_LISTO) || (estado_q == ESPERA_BAJA) ||
             (estado_q == ESPERA_ALTA);
    wd_d   = ((estado_d != estado_q) || !espera) ? 16'd0 : wd_q + 16'd1;

    inicie_d  = (estado_d == LANZA) || (estado_d == ESPERA_BAJA);
    ack_0_d   = (estado_d == ENTREGA) && !canal_d;
    ack_1_d   = (estado_d == ENTREGA) && canal_d;
    ocupado_d = (estado_d != OCIOSO);
  end

  assign bus.ack_0     = ack_0_q;
  assign bus.ack_1     = ack_1_q;
  assign bus.resultado = resultado_q;
  assign bus.error     = error_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.dividendo = dividendo_q;
  assign bus.divisor   = divisor_q;
  assign bus.inicie    = inicie_q;

endmodule

// File: tb/tb_divisor_arbitro.sv
// Purpose: self-checking bench for divisor_arbitro with T_MAX = 16.
//   A behavioural divider drives the divider side of the interface.
//   Its latency is adjustable, and it can be made to hang.
//   Per-channel queues hold the outstanding requests.
//   At every ack, the expected channel comes from the round-robin rule.
//   The expected result comes from plain arithmetic on the queued operands.
module tb_divisor_arbitro;

  typedef struct packed {
    logic [31:0] dd;
    logic [15:0] dv;
  } op_t;

  logic reloj;
  logic reset;

  divisor_arbitro_if #(.DD_W(32), .DV_W(16), .Q_W(32)) bus ();

  divisor_arbitro #(.DD_W(32), .DV_W(16), .Q_W(32), .T_MAX(16)) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus)
  );

  int   checks;
  int   failures;
  int   acks;
  int   prio_m;
  logic inicie_seen;
  op_t  q0[$];
  op_t  q1[$];
  int   ack_log[$];

  logic        div_busy;
  logic        div_hang;
  int          div_lat;
  int          div_cnt;
  logic [31:0] div_dd;
  logic [15:0] div_dv;

  // Free-running clock.
  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Behavioural divider.
  // It is ready with termino high when idle.
  // It takes the operands on inicie and keeps termino low for div_lat cycles.
  // It then presents the quotient.
  always @(posedge reloj or posedge reset) begin
    if (reset) begin
      div_busy     <= 1'b0;
      div_cnt      <= 0;
      div_dd       <= '0;
      div_dv       <= '0;
      bus.termino  <= 1'b1;
      bus.cociente <= '0;
    end else if (div_busy) begin
      if (!div_hang) begin
        if (div_cnt <= 1) begin
          div_busy     <= 1'b0;
          bus.termino  <= 1'b1;
          bus.cociente <= (div_dv == 0) ? '1 : div_dd / {16'd0, div_dv};
        end else begin
          div_cnt <= div_cnt - 1;
        end
      end
    end else if (bus.inicie) begin
      div_busy    <= 1'b1;
      div_cnt     <= div_lat;
      div_dd      <= bus.dividendo;
      div_dv      <= bus.divisor;
      bus.termino <= 1'b0;
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Queues one request on a channel.
  task automatic applyStimulus(input int ch, input logic [31:0] dd, input logic [15:0] dv);
    op_t op;
    op.dd = dd;
    op.dv = dv;
    if (ch == 0) q0.push_back(op);
    else         q1.push_back(op);
  endtask

  // Checks one observed ack against the reference.
  // While both channels have work pending, the arbiter grants the channel named by the priority.
  // Otherwise it grants whichever channel has work.
  task automatic handleAck(input int c);
    int          exp_ch;
    op_t         op;
    logic [31:0] exp_res;
    logic        exp_err;
    if (q0.size() > 0 && q1.size() > 0) exp_ch = prio_m;
    else if (q0.size() > 0)             exp_ch = 0;
    else if (q1.size() > 0)             exp_ch = 1;
    else                                exp_ch = 2;
    checkOutput("ack_channel", c, exp_ch);
    checkOutput("inicie_at_ack", bus.inicie, 1'b0);
    checkOutput("ocupado_at_ack", bus.ocupado, 1'b1);
    if ((c == 0 && q0.size() > 0) || (c == 1 && q1.size() > 0)) begin
      op = (c == 0) ? q0[0] : q1[0];
      if (op.dv == 0) begin
        exp_err = 1'b1;
        exp_res = 32'hFFFF_FFFF;
        checkOutput("zero_no_inicie", inicie_seen, 1'b0);
      end else if (div_hang) begin
        exp_err = 1'b1;
        exp_res = 32'h0;
      end else begin
        exp_err = 1'b0;
        exp_res = op.dd / {16'd0, op.dv};
        checkOutput("inicie_used", inicie_seen, 1'b1);
      end
      checkOutput("resultado", bus.resultado, exp_res);
      checkOutput("error", bus.error, exp_err);
      if (c == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    prio_m = (c == 0) ? 1 : 0;
    ack_log.push_back(c);
    acks++;
    inicie_seen = 1'b0;
  endtask

  // One clock cycle, working away from the active edge.
  // Outputs are observed at the falling edge.
  // The request lines are then driven from the queue heads.
  task automatic runCycle();
    @(negedge reloj);
    if (bus.inicie) inicie_seen = 1'b1;
    if (bus.ack_0) handleAck(0);
    if (bus.ack_1) handleAck(1);
    if (q0.size() > 0) begin
      bus.sol_0 = 1'b1;
      bus.dd_0  = q0[0].dd;
      bus.dv_0  = q0[0].dv;
    end else begin
      bus.sol_0 = 1'b0;
    end
    if (q1.size() > 0) begin
      bus.sol_1 = 1'b1;
      bus.dd_1  = q1[0].dd;
      bus.dv_1  = q1[0].dv;
    end else begin
      bus.sol_1 = 1'b0;
    end
  endtask

  task automatic runUntilEmpty(output int used);
    used = 0;
    while ((q0.size() + q1.size()) > 0 && used < 400) begin
      runCycle();
      used++;
    end
    checkOutput("queues_drained", q0.size() + q1.size(), 0);
  endtask

  // Lets a hung divider finish, so that it is ready for the next test.
  task automatic releaseDivider();
    int n;
    div_hang = 1'b0;
    n = 0;
    while (!bus.termino && n < 40) begin
      runCycle();
      n++;
    end
    checkOutput("divider_ready", bus.termino, 1'b1);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    bus.sol_0 = 1'b0;
    bus.sol_1 = 1'b0;
    q0.delete();
    q1.delete();
    prio_m      = 0;
    inicie_seen = 1'b0;
    repeat (3) @(negedge reloj);
    reset = 1'b0;
  endtask

  initial begin
    int   used;
    int   acks_before;
    logic found;

    checks      = 0;
    failures    = 0;
    acks        = 0;
    prio_m      = 0;
    inicie_seen = 1'b0;
    div_hang    = 1'b0;
    div_lat     = 3;
    reset       = 1'b1;
    bus.sol_0   = 1'b0;
    bus.sol_1   = 1'b0;
    bus.dd_0    = '0;
    bus.dd_1    = '0;
    bus.dv_0    = '0;
    bus.dv_1    = '0;

    // Values held while reset is asserted.
    repeat (2) @(negedge reloj);
    checkOutput("rst_ack_0", bus.ack_0, 1'b0);
    checkOutput("rst_ack_1", bus.ack_1, 1'b0);
    checkOutput("rst_resultado", bus.resultado, 32'h0);
    checkOutput("rst_error", bus.error, 1'b0);
    checkOutput("rst_ocupado", bus.ocupado, 1'b0);
    checkOutput("rst_dividendo", bus.dividendo, 32'h0);
    checkOutput("rst_divisor", bus.divisor, 16'h0);
    checkOutput("rst_inicie", bus.inicie, 1'b0);
    doReset();

    $display("[TB] single request on channel 0");
    applyStimulus(0, 32'h352, 16'h3);
    runUntilEmpty(used);
    checkOutput("single_result_const", bus.resultado, 32'h11B);

    $display("[TB] simultaneous requests after reset");
    doReset();
    ack_log.delete();
    applyStimulus(0, 32'd1024, 16'h20);
    applyStimulus(1, 32'hFFFF_FF24, 16'h21);
    runUntilEmpty(used);
    checkOutput("simul_acks", ack_log.size(), 2);
    if (ack_log.size() == 2) checkOutput("simul_first", ack_log[0], 0);

    $display("[TB] continuous requests on both channels");
    ack_log.delete();
    applyStimulus(0, $urandom, 16'($urandom_range(1, 65535)));
    applyStimulus(0, $urandom, 16'($urandom_range(1, 65535)));
    applyStimulus(1, $urandom, 16'($urandom_range(1, 65535)));
    applyStimulus(1, $urandom, 16'($urandom_range(1, 65535)));
    runUntilEmpty(used);
    checkOutput("cont_acks", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size(); i++) checkOutput("cont_order", ack_log[i], i % 2);

    $display("[TB] zero divisor on channel 1");
    applyStimulus(1, $urandom, 16'h0);
    runUntilEmpty(used);
    checkOutput("zero_latency_ok", used <= 3, 1'b1);

    $display("[TB] divider timeout");
    div_hang = 1'b1;
    applyStimulus(0, $urandom, 16'h7);
    runUntilEmpty(used);
    checkOutput("timeout_inicie_low", bus.inicie, 1'b0);
    releaseDivider();

    $display("[TB] reset while waiting for the quotient");
    div_lat = 10;
    applyStimulus(0, $urandom, 16'h5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      runCycle();
      if (div_busy && !bus.inicie && bus.ocupado) found = 1'b1;
    end
    checkOutput("reached_espera_alta", found, 1'b1);
    checkOutput("ocupado_before_reset", bus.ocupado, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_inicie", bus.inicie, 1'b0);
    checkOutput("reset_ocupado", bus.ocupado, 1'b0);
    bus.sol_0 = 1'b0;
    bus.sol_1 = 1'b0;
    q0.delete();
    q1.delete();
    prio_m      = 0;
    inicie_seen = 1'b0;
    @(negedge reloj);
    reset = 1'b0;
    acks_before = acks;
    repeat (20) runCycle();
    checkOutput("no_ack_after_reset", acks - acks_before, 0);
    div_lat = 2;
    applyStimulus(0, 32'd1000, 16'd7);
    runUntilEmpty(used);
    checkOutput("post_reset_acks", acks - acks_before, 1);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 24; r++) begin
      int n0;
      int n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      div_hang = ($urandom_range(0, 7) == 0);
      div_lat  = $urandom_range(1, 8);
      for (int k = 0; k < n0; k++)
        applyStimulus(0, $urandom, ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
      for (int k = 0; k < n1; k++)
        applyStimulus(1, $urandom, ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
      runUntilEmpty(used);
      if (div_hang) releaseDivider();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
